control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 45 ++++
 rtl/control_imm_gen.sv | 30 +++
 rtl/control.sv | 174 +++++++++++++++++
 tb/tb_control.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared decode types, ALU operation codes and RV32I opcode constants.
// Revision 1.0 -- initial release.
`default_nettype none

package control_pkg;

  typedef enum logic [5:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU, CU_XORI, CU_ORI, CU_ANDI,
    CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
    CU_ERROR
  } cuOPType;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_sel_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

`default_nettype wire

// File: rtl/control_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction into a 20-bit field.
// Revision 1.0 -- initial release.
`default_nettype none

module imm_gen
  import control_pkg::*;
(
  input  logic [31:0] instruction,
  input  imm_sel_t    imm_sel,
  output logic [19:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:     imm = {{8{instruction[31]}}, instruction[31:20]};
      IMM_S:     imm = {{8{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B:     imm = {{7{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:     imm = instruction[31:12];
      // J offset keeps bits 20:1; bit 0 is implicitly zero
      IMM_J:     imm = {instruction[31], instruction[19:12], instruction[20], instruction[30:21]};
      IMM_SHAMT: imm = {15'd0, instruction[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control.sv
// control: registered RV32I instruction decoder (1-cycle latency).
// Revision 1.0 -- optional macro CONTROL_STRICT_FUNCT7_EN enforces legal funct7 encodings.
`default_nettype none

module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic [31:0] instruction,
  output cuOPType     cuOP,
  output logic [4:0]  reg_1,
  output logic [4:0]  reg_2,
  output logic [4:0]  rd,
  output logic [19:0] imm,
  output logic [3:0]  aluOP,
  output logic        regWrite,
  output logic        memWrite,
  output logic        memRead,
  output logic        aluSrc
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  cuOPType     op_d;
  imm_sel_t    imm_sel;
  logic [19:0] imm_d;
  logic [3:0]  alu_d;
  logic        reg_write_d, mem_write_d, mem_read_d, alu_src_d;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign alt    = instruction[30];

  imm_gen u_imm_gen (
    .instruction (instruction),
    .imm_sel     (imm_sel),
    .imm         (imm_d)
  );

  always_comb begin
    op_d        = CU_ERROR;
    imm_sel     = IMM_NONE;
    alu_d       = ALU_ADD;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    alu_src_d   = 1'b0;
    case (opcode)
      OP_LUI:   begin op_d = CU_LUI;   imm_sel = IMM_U; reg_write_d = 1'b1; alu_src_d = 1'b1; end
      OP_AUIPC: begin op_d = CU_AUIPC; imm_sel = IMM_U; reg_write_d = 1'b1; alu_src_d = 1'b1; end
      OP_JAL:   begin op_d = CU_JAL;   imm_sel = IMM_J; reg_write_d = 1'b1; alu_src_d = 1'b1; end
      OP_JALR: begin
        if (funct3 == 3'b000) op_d = CU_JALR;
        imm_sel = IMM_I; reg_write_d = 1'b1; alu_src_d = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  op_d = CU_BEQ;
          3'b001:  op_d = CU_BNE;
          3'b100:  op_d = CU_BLT;
          3'b101:  op_d = CU_BGE;
          3'b110:  op_d = CU_BLTU;
          3'b111:  op_d = CU_BGEU;
          default: op_d = CU_ERROR;
        endcase
        imm_sel = IMM_B; alu_d = ALU_SUB;
      end
      OP_LOAD: begin
        case (funct3)
          3'b000:  op_d = CU_LB;
          3'b001:  op_d = CU_LH;
          3'b010:  op_d = CU_LW;
          3'b100:  op_d = CU_LBU;
          3'b101:  op_d = CU_LHU;
          default: op_d = CU_ERROR;
        endcase
        imm_sel = IMM_I; reg_write_d = 1'b1; mem_read_d = 1'b1; alu_src_d = 1'b1;
      end
      OP_STORE: begin
        case (funct3)
          3'b000:  op_d = CU_SB;
          3'b001:  op_d = CU_SH;
          3'b010:  op_d = CU_SW;
          default: op_d = CU_ERROR;
        endcase
        imm_sel = IMM_S; mem_write_d = 1'b1; alu_src_d = 1'b1;
      end
      OP_IMM: begin
        imm_sel = IMM_I; reg_write_d = 1'b1; alu_src_d = 1'b1;
        case (funct3)
          3'b000: begin op_d = CU_ADDI;  alu_d = ALU_ADD;  end
          3'b010: begin op_d = CU_SLTI;  alu_d = ALU_SLT;  end
          3'b011: begin op_d = CU_SLTIU; alu_d = ALU_SLTU; end
          3'b100: begin op_d = CU_XORI;  alu_d = ALU_XOR;  end
          3'b110: begin op_d = CU_ORI;   alu_d = ALU_OR;   end
          3'b111: begin op_d = CU_ANDI;  alu_d = ALU_AND;  end
          3'b001: begin
            op_d = CU_SLLI; alu_d = ALU_SLL; imm_sel = IMM_SHAMT;
`ifdef CONTROL_STRICT_FUNCT7_EN
            if (instruction[31:25] != 7'h00) op_d = CU_ERROR;
`endif
          end
          default: begin
            op_d    = alt ? CU_SRAI : CU_SRLI;
            alu_d   = alt ? ALU_SRA : ALU_SRL;
            imm_sel = IMM_SHAMT;
`ifdef CONTROL_STRICT_FUNCT7_EN
            if (instruction[31:25] != {1'b0, alt, 5'b0}) op_d = CU_ERROR;
`endif
          end
        endcase
      end
      OP_REG: begin
        reg_write_d = 1'b1;
        case (funct3)
          3'b000:  begin op_d = alt ? CU_SUB : CU_ADD; alu_d = alt ? ALU_SUB : ALU_ADD; end
          3'b001:  begin op_d = CU_SLL;  alu_d = ALU_SLL;  end
          3'b010:  begin op_d = CU_SLT;  alu_d = ALU_SLT;  end
          3'b011:  begin op_d = CU_SLTU; alu_d = ALU_SLTU; end
          3'b100:  begin op_d = CU_XOR;  alu_d = ALU_XOR;  end
          3'b101:  begin op_d = alt ? CU_SRA : CU_SRL; alu_d = alt ? ALU_SRA : ALU_SRL; end
          3'b110:  begin op_d = CU_OR;   alu_d = ALU_OR;   end
          default: begin op_d = CU_AND;  alu_d = ALU_AND;  end
        endcase
`ifdef CONTROL_STRICT_FUNCT7_EN
        if (!((instruction[31:25] == 7'h00) ||
              (instruction[31:25] == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
          op_d = CU_ERROR;
`endif
      end
      default: op_d = CU_ERROR;
    endcase
    // Any rejected encoding collapses to a fully inert decode
    if (op_d == CU_ERROR) begin
      imm_sel     = IMM_NONE;
      alu_d       = ALU_ADD;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      alu_src_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      cuOP     <= CU_ERROR;
      reg_1    <= '0;
      reg_2    <= '0;
      rd       <= '0;
      imm      <= '0;
      aluOP    <= '0;
      regWrite <= 1'b0;
      memWrite <= 1'b0;
      memRead  <= 1'b0;
      aluSrc   <= 1'b0;
    end else begin
      cuOP     <= op_d;
      reg_1    <= instruction[19:15];
      reg_2    <= instruction[24:20];
      rd       <= instruction[11:7];
      imm      <= imm_d;
      aluOP    <= alu_d;
      regWrite <= reg_write_d;
      memWrite <= mem_write_d;
      memRead  <= mem_read_d;
      aluSrc   <= alu_src_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control.sv
// tb_control: randomized self-checking bench for control against a table-driven RV32I decode model.
// Revision 1.0 -- initial release.
`default_nettype none

module tb_control;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] instruction = '0;
  logic [5:0]  cuOP;
  logic [4:0]  reg_1, reg_2, rd;
  logic [19:0] imm;
  logic [3:0]  aluOP;
  logic        regWrite, memWrite, memRead, aluSrc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  r1, r2, rd;
    logic [19:0] imm;
    logic [3:0]  alu;
    logic        rw, mw, mr, src;
  } exp_t;

  // aluOP selected by funct3 (SUB/SRA add one via instr[30]); R-type op = 28 + aluOP
  localparam int ALU_BY_F3 [8]  = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam int IMM_OP_BY_ALU [10] = '{18, -1, 25, 19, 20, 22, 26, 27, 23, 24};
  localparam int BR_IDX [8]     = '{0, 1, -1, -1, 2, 3, 4, 5};
  localparam int LD_IDX [8]     = '{0, 1, 2, -1, 3, 4, -1, -1};
  localparam int OP_ERR = 38;
  localparam logic [6:0] OPCODES [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  control dut (
    .clk(clk), .nRst(nRst), .instruction(instruction), .cuOP(cuOP),
    .reg_1(reg_1), .reg_2(reg_2), .rd(rd), .imm(imm), .aluOP(aluOP),
    .regWrite(regWrite), .memWrite(memWrite), .memRead(memRead), .aluSrc(aluSrc)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] in);
    exp_t e;
    int f3, alu, idx;
    logic ok;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    int v;
    f3 = int'(in[14:12]);
    ok = 1'b1;
    e = '0;
    e.r1 = in[19:15]; e.r2 = in[24:20]; e.rd = in[11:7];
    i12 = in[31:20];
    s12 = {in[31:25], in[11:7]};
    b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    case (in[6:0])
      7'h37, 7'h17: begin
        e.op = (in[6:0] == 7'h37) ? 6'd0 : 6'd1;
        e.imm = in[31:12]; e.rw = 1; e.src = 1;
      end
      7'h6F: begin
        e.op = 2; e.imm = {in[31], in[19:12], in[20], in[30:21]}; e.rw = 1; e.src = 1;
      end
      7'h67: begin
        ok = (f3 == 0); e.op = 3; v = i12; e.imm = v[19:0]; e.rw = 1; e.src = 1;
      end
      7'h63: begin
        idx = BR_IDX[f3]; ok = (idx >= 0); e.op = 6'(4 + idx);
        v = b13; e.imm = v[19:0]; e.alu = 1;
      end
      7'h03: begin
        idx = LD_IDX[f3]; ok = (idx >= 0); e.op = 6'(10 + idx);
        v = i12; e.imm = v[19:0]; e.rw = 1; e.mr = 1; e.src = 1;
      end
      7'h23: begin
        ok = (f3 < 3); e.op = 6'(15 + f3); v = s12; e.imm = v[19:0]; e.mw = 1; e.src = 1;
      end
      7'h13: begin
        alu = ALU_BY_F3[f3] + ((f3 == 5 && in[30]) ? 1 : 0);
        e.op = 6'(IMM_OP_BY_ALU[alu]); e.alu = 4'(alu); e.rw = 1; e.src = 1;
        if (f3 == 1 || f3 == 5) e.imm = {15'd0, in[24:20]};
        else begin v = i12; e.imm = v[19:0]; end
`ifdef CONTROL_STRICT_FUNCT7_EN
        if (f3 == 1) ok = (in[31:25] == 7'h00);
        if (f3 == 5) ok = (in[31:25] == 7'h00) || (in[31:25] == 7'h20);
`endif
      end
      7'h33: begin
        alu = ALU_BY_F3[f3] + (((f3 == 0 || f3 == 5) && in[30]) ? 1 : 0);
        e.op = 6'(28 + alu); e.alu = 4'(alu); e.rw = 1;
`ifdef CONTROL_STRICT_FUNCT7_EN
        ok = (in[31:25] == 7'h00) || (in[31:25] == 7'h20 && (f3 == 0 || f3 == 5));
`endif
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.op = 6'(OP_ERR); e.imm = '0; e.alu = '0;
      e.rw = 0; e.mw = 0; e.mr = 0; e.src = 0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (instr 0x%08h nRst %0b)", tag, got, want, instruction, nRst);
    end
  endtask

  // Apply one instruction/reset value, let one edge pass, then compare every output.
  task automatic step(input logic [31:0] ins, input logic rst_n);
    exp_t e;
    instruction = ins;
    nRst = rst_n;
    @(posedge clk);
    #1;
    if (rst_n) e = model(ins);
    else begin e = '0; e.op = 6'(OP_ERR); end
    check("cuOP", 32'(cuOP), 32'(e.op));
    check("reg_1", 32'(reg_1), 32'(e.r1));
    check("reg_2", 32'(reg_2), 32'(e.r2));
    check("rd", 32'(rd), 32'(e.rd));
    check("imm", 32'(imm), 32'(e.imm));
    check("aluOP", 32'(aluOP), 32'(e.alu));
    check("regWrite", 32'(regWrite), 32'(e.rw));
    check("memWrite", 32'(memWrite), 32'(e.mw));
    check("memRead", 32'(memRead), 32'(e.mr));
    check("aluSrc", 32'(aluSrc), 32'(e.src));
  endtask

  initial begin
    logic [31:0] r;
    // Reset state, then the reference vectors
    step(32'h3E800093, 1'b0);
    step(32'h3E800093, 1'b1);
    check("addi_imm_lit", 32'(imm), 32'h003E8);
    check("addi_op_lit", 32'(cuOP), 32'd18);
    step(32'h83000113, 1'b1);
    check("addi_neg_imm_lit", 32'(imm), 32'hFF830);
    step(32'h3E906193, 1'b1);
    check("ori_alu_lit", 32'(aluOP), 32'd8);
    step(32'h45707213, 1'b1);
    check("andi_imm_lit", 32'(imm), 32'h00457);
    step(32'hEEAC2723, 1'b1);
    check("sw_op_lit", 32'(cuOP), 32'd17);
    check("sw_imm_lit", 32'(imm), 32'hFFEEE);
    check("sw_memWrite_lit", 32'(memWrite), 32'd1);
    step(32'h00000000, 1'b1);
    check("zero_is_error_lit", 32'(cuOP), 32'd38);
    step(32'h3E800093, 1'b0);
    step(32'h40208033, 1'b1);   // SUB: decoded on the first edge after reset release
    step(32'h4020D013, 1'b1);   // SRAI
    step(32'h0020D013, 1'b1);   // SRLI
    step(32'hFFF00067, 1'b1);   // JALR, negative offset
    step(32'h800000EF, 1'b1);   // JAL, most negative offset
    step(32'hFE000FE3, 1'b1);   // BEQ, negative offset
    step(32'h00002063, 1'b1);   // branch funct3=010 is illegal
    // Randomized mix of legal opcodes, stray opcodes and occasional resets
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = OPCODES[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      step(r, ($urandom_range(0, 15) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
